// File: rtl/axi4_lite_slave_regfile.sv
// axi4_lite_slave_regfile
//
// AXI4-Lite slave that terminates all five channels onto a bank of
// NUM_REGS software-visible registers. The register contents are also
// exported flat on reg_out for direct observation.
//
// Ports:
//   aclk, areset          clock, asynchronous active-high reset
//   aw*/w*/b*             write address / data / response channels
//   ar*/r*                read address / data channels
//   reg_out               reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//
// Write path: AW and W beats are captured independently; the write commits
// in the cycle the second of the two is present (held or handshaking), then
// the response is held until bready. Read path: one outstanding read, data
// sampled from the registers at the AR handshake (so a same-cycle write to
// the same register is not visible in that read).
module axi4_lite_slave_regfile #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDRESS_WIDTH-1:0]       awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDRESS_WIDTH-1:0]       araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int IDXW  = ADDRESS_WIDTH - OFS;
  localparam int RIW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_COLLECT, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t              w_state_q, w_state_d;
  r_state_t              r_state_q, r_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [IDXW-1:0]       awidx_q, awidx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]      wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [DATA_WIDTH-1:0] reg_rd [NUM_REGS];

  logic                  aw_hs, w_hs, ar_hs, wr_commit;
  logic [IDXW-1:0]       wr_idx, ar_idx;
  logic                  wr_in_range, ar_in_range;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BYTES-1:0]      wr_strb;

  // Handshake-ready outputs are gated by areset directly so they drop
  // in the same instant reset asserts.
  assign bvalid  = (w_state_q == W_RESP);
  assign rvalid  = (r_state_q == R_DATA);
  assign awready = !areset && !aw_held_q && !bvalid;
  assign wready  = !areset && !w_held_q && !bvalid;
  assign arready = !areset && !rvalid;
  assign bresp   = bresp_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // A held beat takes precedence; otherwise the live beat is used.
  assign wr_idx      = aw_held_q ? awidx_q : awaddr[ADDRESS_WIDTH-1:OFS];
  assign wr_data     = w_held_q ? wdata_q : wdata;
  assign wr_strb     = w_held_q ? wstrb_q : wstrb;
  assign wr_commit   = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_in_range = (wr_idx < IDXW'(NUM_REGS));

  assign ar_idx      = araddr[ADDRESS_WIDTH-1:OFS];
  assign ar_in_range = (ar_idx < IDXW'(NUM_REGS));

  logic unused_bits;
  assign unused_bits = ^{awprot, arprot, awaddr[OFS-1:0], araddr[OFS-1:0]};

  // Write-path FSM
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_COLLECT: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awidx_d   = awaddr[ADDRESS_WIDTH-1:OFS];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if (wr_commit) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) w_state_d = W_COLLECT;
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q <= W_COLLECT;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read-path FSM; data is taken from the current (pre-write) register value.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d   = ar_in_range ? reg_rd[ar_idx[RIW-1:0]] : '0;
          rresp_d   = ar_in_range ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Register bank: one byte-enabled register per index.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] reg_q, reg_d;

      always_comb begin
        reg_d = reg_q;
        if (wr_commit && wr_in_range && (wr_idx == IDXW'(gi))) begin
          for (int b = 0; b < BYTES; b++) begin
            if (wr_strb[b]) reg_d[b*8 +: 8] = wr_data[b*8 +: 8];
          end
        end
      end

      always_ff @(posedge aclk or posedge areset) begin
        if (areset) reg_q <= '0;
        else        reg_q <= reg_d;
      end

      assign reg_rd[gi] = reg_q;
      assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = reg_q;
    end
  endgenerate

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed testbench for axi4_lite_slave_regfile (default parameters:
// 32-bit address/data, 16 registers). Inputs are driven and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_axi4_lite_slave_regfile;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic           aclk = 1'b0;
  logic           areset = 1'b0;
  logic [AW-1:0]  awaddr = '0;
  logic [2:0]     awprot = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [DW-1:0]  wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready = 1'b1;
  logic [AW-1:0]  araddr = '0;
  logic [2:0]     arprot = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready = 1'b1;
  logic [NR*DW-1:0] reg_out;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi4_lite_slave_regfile #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS(NR)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out)
  );

  function automatic logic [DW-1:0] reg_val(input int i);
    return reg_out[i*DW +: DW];
  endfunction

  // Full write with AW and W presented together; returns bresp.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(negedge aclk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge aclk); n++; end
    checks++;
    if (!bvalid) begin
      errors++;
      $display("FAIL write_timeout: bvalid=%b required 1 (addr %h)", bvalid, addr);
    end
    resp = bresp;
    @(negedge aclk);
    $display("write addr=%h data=%h strb=%h bresp=%b", addr, data, strb, resp);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp);
    int n;
    @(negedge aclk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge aclk); n++; end
    checks++;
    if (!rvalid) begin
      errors++;
      $display("FAIL read_timeout: rvalid=%b required 1 (addr %h)", rvalid, addr);
    end
    data = rdata; resp = rresp;
    @(negedge aclk);
    $display("read  addr=%h rdata=%h rresp=%b", addr, data, resp);
  endtask

  task automatic test_reset();
    #2 areset = 1'b1;
    @(negedge aclk);
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready: aw/w/ar ready=%b required 000", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valid: bvalid,rvalid=%b required 00", {bvalid, rvalid});
    end
    checks++;
    if (reg_out !== '0 || rdata !== '0 || bresp !== 2'b00 || rresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_values: reg_out/rdata/bresp/rresp nonzero, rdata=%h", rdata);
    end
    @(negedge aclk);
    areset = 1'b0;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL release_ready: aw/w/ar ready=%b required 111", {awready, wready, arready});
    end
    $display("reset released");
  endtask

  task automatic test_basic_write();
    logic [DW-1:0] d;
    logic [1:0]    r;
    @(negedge aclk);
    awaddr = 32'h8; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    checks++;
    if ({awready, wready} !== 2'b11) begin
      errors++;
      $display("FAIL basic_ready: awready,wready=%b required 11", {awready, wready});
    end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL basic_bvalid: bvalid=%b bresp=%b required 1 00", bvalid, bresp);
    end
    checks++;
    if (reg_val(2) !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_reg2: reg_out[2]=%h required deadbeef", reg_val(2));
    end
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      errors++;
      $display("FAIL basic_bdone: bvalid=%b awready=%b required 0 1", bvalid, awready);
    end
    $display("write addr=00000008 data=deadbeef strb=f (inline)");
    axi_read(32'h8, d, r);
    checks++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      errors++;
      $display("FAIL basic_read: rdata=%h rresp=%b required deadbeef 00", d, r);
    end
  endtask

  task automatic test_split_w_first();
    @(negedge aclk);
    wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1; bready = 1'b1;
    checks++;
    if (wready !== 1'b1) begin
      errors++;
      $display("FAIL split_wready_before: wready=%b required 1", wready);
    end
    @(negedge aclk);
    wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wready !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b1) begin
        errors++;
        $display("FAIL split_hold: wready=%b bvalid=%b awready=%b required 0 0 1",
                 wready, bvalid, awready);
      end
      @(negedge aclk);
    end
    checks++;
    if (wready !== 1'b0 || bvalid !== 1'b0) begin
      errors++;
      $display("FAIL split_hold3: wready=%b bvalid=%b required 0 0", wready, bvalid);
    end
    awaddr = 32'h4; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL split_bvalid: bvalid=%b bresp=%b required 1 00", bvalid, bresp);
    end
    checks++;
    if (reg_val(1) !== 32'h00220044) begin
      errors++;
      $display("FAIL split_reg1: reg_out[1]=%h required 00220044", reg_val(1));
    end
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b0 || wready !== 1'b1) begin
      errors++;
      $display("FAIL split_done: bvalid=%b wready=%b required 0 1", bvalid, wready);
    end
    $display("write split addr=00000004 data=11223344 strb=5");
  endtask

  task automatic test_strobe();
    logic [1:0] r;
    axi_write(32'h8, 32'hAABBCCDD, 4'hA, r);
    checks++;
    if (r !== 2'b00 || reg_val(2) !== 32'hAAADCCEF) begin
      errors++;
      $display("FAIL strobe_merge: bresp=%b reg_out[2]=%h required 00 aaadccef", r, reg_val(2));
    end
  endtask

  task automatic test_out_of_range();
    logic [NR*DW-1:0] saved;
    logic [DW-1:0] d;
    logic [1:0]    r;
    saved = reg_out;
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin
      errors++;
      $display("FAIL oor_bresp: bresp=%b required 10", r);
    end
    checks++;
    if (reg_out !== saved) begin
      errors++;
      $display("FAIL oor_regs: reg_out changed, reg_out[0]=%h required %h", reg_val(0), saved[DW-1:0]);
    end
    axi_read(32'h40, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++;
      $display("FAIL oor_read: rdata=%h rresp=%b required 00000000 10", d, r);
    end
  endtask

  task automatic test_backpressure();
    @(negedge aclk);
    bready = 1'b0;
    awaddr = 32'h0; wdata = 32'h12345678; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: bvalid=%b bresp=%b awready=%b wready=%b required 1 00 0 0",
                 i, bvalid, bresp, awready, wready);
      end
      @(negedge aclk);
    end
    bready = 1'b1;
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || reg_val(0) !== 32'h12345678) begin
      errors++;
      $display("FAIL bp_release: bvalid=%b awready=%b reg0=%h required 0 1 12345678",
               bvalid, awready, reg_val(0));
    end
    $display("write backpressured addr=00000000 data=12345678");
  endtask

  task automatic test_collision();
    logic [DW-1:0] d;
    logic [1:0]    r;
    axi_write(32'hC, 32'h5, 4'hF, r);
    @(negedge aclk);
    awaddr = 32'hC; wdata = 32'hA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'hC; arvalid = 1'b1; rready = 1'b1; bready = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h5) begin
      errors++;
      $display("FAIL coll_old: rvalid=%b rdata=%h required 1 00000005", rvalid, rdata);
    end
    checks++;
    if (bvalid !== 1'b1 || reg_val(3) !== 32'hA) begin
      errors++;
      $display("FAIL coll_write: bvalid=%b reg3=%h required 1 0000000a", bvalid, reg_val(3));
    end
    @(negedge aclk);
    $display("collision addr=0000000c read old, write 0000000a");
    axi_read(32'hC, d, r);
    checks++;
    if (d !== 32'hA || r !== 2'b00) begin
      errors++;
      $display("FAIL coll_new: rdata=%h rresp=%b required 0000000a 00", d, r);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge aclk);
    bready = 1'b1;
    awaddr = 32'h10; wdata = 32'h01010101; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b1 || awready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: bvalid=%b awready=%b required 1 0", bvalid, awready);
    end
    awaddr = 32'h14; wdata = 32'h02020202;
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: bvalid=%b awready=%b required 0 1", bvalid, awready);
    end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || reg_val(4) !== 32'h01010101 || reg_val(5) !== 32'h02020202) begin
      errors++;
      $display("FAIL b2b_regs: bvalid=%b reg4=%h reg5=%h required 1 01010101 02020202",
               bvalid, reg_val(4), reg_val(5));
    end
    @(negedge aclk);
    $display("write back-to-back addr=00000010,00000014");
  endtask

  task automatic test_reset_mid();
    @(negedge aclk);
    rready = 1'b0;
    awaddr = 32'h8; awvalid = 1'b1;
    araddr = 32'h8; arvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || awready !== 1'b0) begin
      errors++;
      $display("FAIL rm_setup: rvalid=%b awready=%b required 1 0", rvalid, awready);
    end
    areset = 1'b1;
    #1;
    checks++;
    if (rvalid !== 1'b0 || reg_out !== '0 || arready !== 1'b0) begin
      errors++;
      $display("FAIL rm_async: rvalid=%b arready=%b reg2=%h required 0 0 00000000",
               rvalid, arready, reg_val(2));
    end
    @(negedge aclk);
    areset = 1'b0;
    rready = 1'b1;
    #1;
    checks++;
    if ({awready, wready, bvalid, rvalid} !== 4'b1100) begin
      errors++;
      $display("FAIL rm_release: aw,w,b,r=%b required 1100", {awready, wready, bvalid, rvalid});
    end
    @(negedge aclk);
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || wready !== 1'b0) begin
      errors++;
      $display("FAIL rm_aw_dropped: bvalid=%b wready=%b required 0 0", bvalid, wready);
    end
    awaddr = 32'h18; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || reg_val(6) !== 32'h77 || reg_val(2) !== 32'h0) begin
      errors++;
      $display("FAIL rm_newwrite: bvalid=%b bresp=%b reg6=%h reg2=%h required 1 00 00000077 00000000",
               bvalid, bresp, reg_val(6), reg_val(2));
    end
    @(negedge aclk);
    $display("reset mid-transaction, then write addr=00000018 data=00000077");
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_split_w_first();
    test_strobe();
    test_out_of_range();
    test_backpressure();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
